// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-push handshake and serial line status of the UART transmitter.
interface uart_tx_if;
  logic       send_en;
  logic [7:0] data_byte;
  logic       fifo_full;
  logic       rs232_tx;
  logic       tx_done;
  logic       uart_state;
  modport master (output send_en, data_byte, input fifo_full, rs232_tx, tx_done, uart_state);
  modport slave (input send_en, data_byte, output fifo_full, rs232_tx, tx_done, uart_state);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a 4-entry byte FIFO, fixed baud select.
module uart_tx #(
  parameter int baud_set = 0
) (
  input logic     clk,
  input logic     rst_n,
  uart_tx_if.slave bus
);
  localparam logic [12:0] BPS_DR = baud_set == 1 ? 13'd2603 : baud_set == 2 ? 13'd1301 :
                                   baud_set == 3 ? 13'd867  : baud_set == 4 ? 13'd433  : 13'd5207;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      r_state;
  logic [7:0]  r_mem [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_count;
  logic        r_avail;
  logic [12:0] r_div;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_tx, r_done, r_busy;
  logic        w_push, w_pop, w_bit_end;
  assign w_push        = bus.send_en && r_count != 3'd4;
  assign w_pop         = r_state == IDLE && r_avail;
  assign w_bit_end     = r_div == BPS_DR;
  assign bus.fifo_full  = r_count == 3'd4;
  assign bus.rs232_tx   = r_tx;
  assign bus.tx_done    = r_done;
  assign bus.uart_state = r_busy;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= bus.data_byte;
  // r_avail lags the count by one clock so a byte pushed into an empty
  // FIFO starts its frame two edges later; it never reads true on an empty FIFO
  // in IDLE because only IDLE pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_avail <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
      r_avail <= r_count != 3'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div  <= r_state == IDLE || w_bit_end ? '0 : r_div + 13'd1;
      case (r_state)
        IDLE: begin
          r_tx   <= ~w_pop;
          r_busy <= w_pop;
          if (w_pop) begin
            r_shift <= r_mem[r_rp];
            r_state <= START;
          end
        end
        START: if (w_bit_end) begin
          r_state <= DATA;
          r_idx   <= '0;
          r_tx    <= r_shift[0];
        end
        DATA: if (w_bit_end) begin
          r_state <= r_idx == 3'd7 ? STOP : DATA;
          r_tx    <= r_idx == 3'd7 ? 1'b1 : r_shift[r_idx + 3'd1];
          r_idx   <= r_idx + 3'd1;
        end
        STOP: if (w_bit_end) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      endcase
    end
  end
endmodule
